// File: rtl/encdec_pkg.sv
// Shared encoder/decoder types, constants and the index-to-one-hot helper.
package encdec_pkg;

  localparam int unsigned N_LINES = 8;
  localparam int unsigned CODE_W  = 3;

  typedef logic [N_LINES-1:0] line_vec_t;
  typedef logic [CODE_W-1:0]  code_t;

  // Output stage occupancy
  typedef enum logic {StEmpty, StFull} oq_state_e;

  // d-index convention: code k drives line k
  function automatic line_vec_t onehot(code_t code);
    line_vec_t vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/prio_enc8x3.sv
// Combinational 8-to-3 priority encoder with selectable priority direction.
module prio_enc8x3
  import encdec_pkg::*;
(
  input  line_vec_t i_vec,
  input  logic      i_low_first,
  output logic      o_found,
  output code_t     o_idx
);

  // Later loop iterations override earlier ones, so scan toward the winning end
  always_comb begin
    o_found = |i_vec;
    o_idx   = '0;
    if (i_low_first) begin
      for (int i = N_LINES - 1; i >= 0; i--) begin
        if (i_vec[i]) o_idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < N_LINES; i++) begin
        if (i_vec[i]) o_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/encoder8x3_event_queue.sv
// Collects one-hot event strobes into a pending set and issues them one at a
// time, in priority order, as 3-bit codes through a valid/ready output stage.
module encoder8x3_event_queue
  import encdec_pkg::*;
#(
  parameter int unsigned LOW_FIRST  = 0,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [7:0]            i_req,
  output logic [2:0]            o_out_code,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [7:0]            o_pending,
  output logic                  o_busy,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  oq_state_e             r_state;
  oq_state_e             w_state_next;
  line_vec_t             r_pending;
  code_t                 r_out_code;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  line_vec_t             w_cap;
  line_vec_t             w_issue_mask;
  line_vec_t             w_merge;
  logic                  w_found;
  code_t                 w_pick;
  logic                  w_load;
  logic [3:0]            w_merge_cnt;
  logic [DROP_CNT_W:0]   w_drop_sum;

  // Pick is taken from the registered set only, so req never reaches outputs
  prio_enc8x3 u_prio_enc (
    .i_vec       (r_pending),
    .i_low_first (LOW_FIRST != 0),
    .o_found     (w_found),
    .o_idx       (w_pick)
  );

  // Capture, issue and merge bookkeeping for this edge
  always_comb begin
    w_cap        = i_en ? i_req : '0;
    w_load       = ((r_state == StEmpty) || i_out_ready) && w_found;
    w_issue_mask = w_load ? onehot(w_pick) : '0;
    // A bit being issued this edge is re-armed by cap, not merged
    w_merge      = w_cap & r_pending & ~w_issue_mask;
    w_merge_cnt  = '0;
    for (int i = 0; i < N_LINES; i++) begin
      w_merge_cnt = w_merge_cnt + {3'b000, w_merge[i]};
    end
    w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W + 1)'(w_merge_cnt);
  end

  // Output stage state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= StEmpty;
    else          r_state <= w_state_next;
  end

  // Output stage next state: load fills, drained ready empties, stall holds
  always_comb begin
    w_state_next = r_state;
    if (w_load) begin
      w_state_next = StFull;
    end else if ((r_state == StFull) && i_out_ready) begin
      w_state_next = StEmpty;
    end
  end

  // Output stage outputs
  always_comb begin
    o_out_valid = (r_state == StFull);
  end

  // Datapath registers: held code, pending set (set beats clear), drop counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_code <= '0;
      r_pending  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_load) r_out_code <= w_pick;
      r_pending <= (r_pending & ~w_issue_mask) | w_cap;
      if (w_drop_sum[DROP_CNT_W]) r_drop_cnt <= '1;
      else                        r_drop_cnt <= w_drop_sum[DROP_CNT_W-1:0];
    end
  end

  assign o_out_code = r_out_code;
  assign o_pending  = r_pending;
  assign o_drop_cnt = r_drop_cnt;
  assign o_busy     = o_out_valid | (|r_pending);

endmodule

// File: tb/tb_encoder8x3_event_queue.sv
// Directed bench: one high-first and one low-first instance share stimulus.
module tb_encoder8x3_event_queue;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       out_ready;

  logic [2:0] hi_code, lo_code;
  logic       hi_valid, lo_valid;
  logic [7:0] hi_pend, lo_pend;
  logic       hi_busy, lo_busy;
  logic [7:0] hi_drop, lo_drop;

  int n_cmp;
  int n_err;

  encoder8x3_event_queue #(.LOW_FIRST(0), .DROP_CNT_W(8)) dut_hi (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_req       (req),
    .o_out_code  (hi_code),
    .o_out_valid (hi_valid),
    .i_out_ready (out_ready),
    .o_pending   (hi_pend),
    .o_busy      (hi_busy),
    .o_drop_cnt  (hi_drop)
  );

  encoder8x3_event_queue #(.LOW_FIRST(1), .DROP_CNT_W(8)) dut_lo (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_req       (req),
    .o_out_code  (lo_code),
    .o_out_valid (lo_valid),
    .i_out_ready (out_ready),
    .o_pending   (lo_pend),
    .o_busy      (lo_busy),
    .o_drop_cnt  (lo_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b0;

    // Reset dominates capture
    repeat (3) tick();
    check_val("rst_pend",  32'(hi_pend),  32'h00);
    check_val("rst_valid", 32'(hi_valid), 32'h0);
    check_val("rst_code",  32'(hi_code),  32'h0);
    check_val("rst_drop",  32'(hi_drop),  32'h00);
    check_val("rst_busy",  32'(hi_busy),  32'h0);
    check_val("rst_lo_pend", 32'(lo_pend), 32'h00);

    rst_n = 1'b1;
    req   = 8'h00;
    tick();
    check_val("rel_pend",  32'(hi_pend),  32'h00);
    check_val("rel_valid", 32'(hi_valid), 32'h0);

    // Disabled capture ignores req
    en  = 1'b0;
    req = 8'hFF;
    repeat (2) tick();
    check_val("en0_pend", 32'(hi_pend), 32'h00);
    check_val("en0_busy", 32'(hi_busy), 32'h0);

    // Single event with consumer always ready
    en        = 1'b1;
    req       = 8'h20;
    out_ready = 1'b1;
    tick();
    req = 8'h00;
    check_val("one_pend1",  32'(hi_pend),  32'h20);
    check_val("one_valid1", 32'(hi_valid), 32'h0);
    check_val("one_busy1",  32'(hi_busy),  32'h1);
    tick();
    check_val("one_valid2", 32'(hi_valid), 32'h1);
    check_val("one_code2",  32'(hi_code),  32'h5);
    check_val("one_pend2",  32'(hi_pend),  32'h00);
    tick();
    check_val("one_valid3", 32'(hi_valid), 32'h0);
    check_val("one_code3",  32'(hi_code),  32'h5);
    check_val("one_busy3",  32'(hi_busy),  32'h0);

    // Backpressure with two events
    out_ready = 1'b0;
    req       = 8'h81;
    tick();
    req = 8'h00;
    check_val("bp_pend0", 32'(hi_pend), 32'h81);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_hi_code",  32'(hi_code),  32'h7);
      check_val("bp_hi_valid", 32'(hi_valid), 32'h1);
      check_val("bp_hi_pend",  32'(hi_pend),  32'h01);
    end
    check_val("bp_lo_code", 32'(lo_code), 32'h0);
    check_val("bp_lo_pend", 32'(lo_pend), 32'h80);
    out_ready = 1'b1;
    tick();
    check_val("bp_hi_code2",  32'(hi_code),  32'h0);
    check_val("bp_hi_valid2", 32'(hi_valid), 32'h1);
    check_val("bp_lo_code2",  32'(lo_code),  32'h7);
    tick();
    check_val("bp_hi_valid3", 32'(hi_valid), 32'h0);
    check_val("bp_lo_valid3", 32'(lo_valid), 32'h0);

    // Issue and capture of the same bit on one edge
    req = 8'h10;
    tick();
    check_val("sim_pend0", 32'(hi_pend), 32'h10);
    tick();
    req = 8'h00;
    check_val("sim_code1",  32'(hi_code),  32'h4);
    check_val("sim_valid1", 32'(hi_valid), 32'h1);
    check_val("sim_pend1",  32'(hi_pend),  32'h10);
    check_val("sim_drop1",  32'(hi_drop),  32'h00);
    tick();
    check_val("sim_code2",  32'(hi_code),  32'h4);
    check_val("sim_valid2", 32'(hi_valid), 32'h1);
    check_val("sim_pend2",  32'(hi_pend),  32'h00);
    check_val("sim_drop2",  32'(hi_drop),  32'h00);
    tick();
    check_val("sim_valid3", 32'(hi_valid), 32'h0);

    // Merge while stalled: first re-arm rides the issue edge, second merges
    out_ready = 1'b0;
    req       = 8'h08;
    tick();
    check_val("mrg_pend1", 32'(hi_pend), 32'h08);
    tick();
    check_val("mrg_code2", 32'(hi_code), 32'h3);
    check_val("mrg_pend2", 32'(hi_pend), 32'h08);
    check_val("mrg_drop2", 32'(hi_drop), 32'h00);
    tick();
    req = 8'h00;
    check_val("mrg_code3", 32'(hi_code), 32'h3);
    check_val("mrg_pend3", 32'(hi_pend), 32'h08);
    check_val("mrg_drop3", 32'(hi_drop), 32'h01);

    // Reset mid-operation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 8'hF0;
    tick();
    tick();
    check_val("mid_pend",  32'(hi_pend),  32'hF0);
    check_val("mid_valid", 32'(hi_valid), 32'h1);
    check_val("mid_code",  32'(hi_code),  32'h7);
    check_val("mid_drop",  32'(hi_drop),  32'h03);
    check_val("mid_lo_code", 32'(lo_code), 32'h4);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("mrst_pend",  32'(hi_pend),  32'h00);
    check_val("mrst_valid", 32'(hi_valid), 32'h0);
    check_val("mrst_code",  32'(hi_code),  32'h0);
    check_val("mrst_drop",  32'(hi_drop),  32'h00);
    rst_n = 1'b1;
    req   = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("post_valid", 32'(hi_valid), 32'h0);
      check_val("post_busy",  32'(hi_busy),  32'h0);
    end

    // Drop counter saturation: one merge per edge from the third edge on
    out_ready = 1'b0;
    req       = 8'h08;
    repeat (102) tick();
    check_val("sat_drop100", 32'(hi_drop), 32'd100);
    repeat (200) tick();
    check_val("sat_drop255", 32'(hi_drop), 32'd255);
    check_val("sat_code",    32'(hi_code), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
